// File: rtl/vera_vram_pkg.sv
// Shared constants for the VRAM arbiter: arbitration modes, host write patterns
// and the RAM data width.
package vera_vram_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    localparam logic [1:0] PAT_BYTE = 2'b00;
    localparam logic [1:0] PAT_PAIR = 2'b01;
    localparam logic [1:0] PAT_SKIP = 2'b10;
    localparam logic [1:0] PAT_BLIT = 2'b11;

    localparam int unsigned RAM_DATA_W = 32;

endpackage

// File: rtl/vram_rr_pick.sv
// Priority picker: returns the first requester found scanning upward from the
// start pointer (round-robin) or from index 0 (fixed priority).
module vram_rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic          mode_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW:0] base;
    logic [IW:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        base    = mode_i ? {1'b0, start_i} : '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = base + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                valid_o               = 1'b1;
                idx_o                 = cand[IW-1:0];
                gnt_o[cand[IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: one byte-oriented host port with write patterns and
// NUM_RD 32-bit read-only client ports, one grant per clock, acks one cycle later.
module vram_arbiter
    import vera_vram_pkg::*;
#(
    parameter int unsigned NUM_RD       = 3,
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned STARVE_LIMIT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W+1:0]        host_addr,
    input  logic [1:0]               host_wrpattern,
    input  logic [31:0]              host_cache32,
    input  logic [7:0]               host_wrdata,
    input  logic                     host_strobe,
    input  logic                     host_write,
    output logic                     host_ack,
    output logic [7:0]               host_rddata,
    output logic [31:0]              host_rddata32,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_strobe,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [31:0]              rd_rddata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [31:0]              ram_wrdata,
    output logic [3:0]               ram_wrbytesel,
    output logic                     ram_write,
    input  logic [31:0]              ram_rddata
);

    localparam int unsigned IdxW      = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned CntW      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_RD - 1);
    localparam logic StarveEn = (STARVE_LIMIT > 0);
    localparam logic RrEn     = (ARB_MODE == ARB_RR);

    logic [CntW-1:0]   starve_q [NUM_RD];
    logic [CntW-1:0]   starve_d [NUM_RD];
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic              host_ack_q, host_ack_d;
    logic [NUM_RD-1:0] rd_ack_q, rd_ack_d;
    logic [1:0]        sel_q, sel_d;
    logic [7:0]        hold8_q, hold8_d;
    logic [31:0]       hold32_q, hold32_d;

    logic [NUM_RD-1:0] starving;
    logic [NUM_RD-1:0] stv_gnt, req_gnt, cli_gnt;
    logic [IdxW-1:0]   stv_idx, req_idx, cli_idx;
    logic              stv_valid, req_valid;
    logic              host_gnt;
    logic [7:0]        live_byte;

    always_comb begin
        starving = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            starving[i] = StarveEn && rd_strobe[i] && (starve_q[i] == StarveMax);
        end
    end

    // Starving clients always resolve lowest index first, independent of ARB_MODE.
    vram_rr_pick #(
        .N  (NUM_RD),
        .IW (IdxW)
    ) u_stv_pick (
        .req_i   (starving),
        .start_i ('0),
        .mode_i  (1'b0),
        .gnt_o   (stv_gnt),
        .idx_o   (stv_idx),
        .valid_o (stv_valid)
    );

    vram_rr_pick #(
        .N  (NUM_RD),
        .IW (IdxW)
    ) u_cli_pick (
        .req_i   (rd_strobe),
        .start_i (rr_ptr_q),
        .mode_i  (RrEn),
        .gnt_o   (req_gnt),
        .idx_o   (req_idx),
        .valid_o (req_valid)
    );

    always_comb begin
        host_gnt = 1'b0;
        cli_gnt  = '0;
        cli_idx  = '0;
        rr_ptr_d = rr_ptr_q;
        // Host writes are never preempted, so escalation only applies to reads/idle.
        if (StarveEn && !host_write && stv_valid) begin
            cli_gnt = stv_gnt;
            cli_idx = stv_idx;
        end else if (host_strobe) begin
            host_gnt = 1'b1;
        end else if (req_valid) begin
            cli_gnt  = req_gnt;
            cli_idx  = req_idx;
            rr_ptr_d = (req_idx == LastIdx) ? '0 : req_idx + 1'b1;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_write = 1'b0;
        if (host_gnt) begin
            ram_addr  = host_addr[ADDR_W+1:2];
            ram_write = host_write;
        end else if (|cli_gnt) begin
            ram_addr = rd_addr[int'(cli_idx)*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        ram_wrdata = {4{host_wrdata}};
        if (host_wrpattern == PAT_BLIT && host_addr[1:0] == 2'b00) begin
            ram_wrdata = host_cache32;
        end
    end

    always_comb begin
        ram_wrbytesel = 4'b0000;
        unique case ({host_wrpattern, host_addr[1:0]})
            {PAT_BYTE, 2'd0}: ram_wrbytesel = 4'b0001;
            {PAT_BYTE, 2'd1}: ram_wrbytesel = 4'b0010;
            {PAT_BYTE, 2'd2}: ram_wrbytesel = 4'b0100;
            {PAT_BYTE, 2'd3}: ram_wrbytesel = 4'b1000;
            {PAT_PAIR, 2'd0}: ram_wrbytesel = 4'b0011;
            {PAT_PAIR, 2'd1}: ram_wrbytesel = 4'b0110;
            {PAT_PAIR, 2'd2}: ram_wrbytesel = 4'b1100;
            {PAT_PAIR, 2'd3}: ram_wrbytesel = 4'b1001;
            {PAT_SKIP, 2'd0}: ram_wrbytesel = 4'b0101;
            {PAT_SKIP, 2'd1}: ram_wrbytesel = 4'b1010;
            {PAT_SKIP, 2'd2}: ram_wrbytesel = 4'b0111;
            {PAT_SKIP, 2'd3}: ram_wrbytesel = 4'b1110;
            {PAT_BLIT, 2'd0}: ram_wrbytesel = 4'b1111;
            {PAT_BLIT, 2'd1}: ram_wrbytesel = 4'b1111;
            {PAT_BLIT, 2'd2}: ram_wrbytesel = 4'b1101;
            {PAT_BLIT, 2'd3}: ram_wrbytesel = 4'b1011;
            default:          ram_wrbytesel = 4'b0000;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            starve_d[i] = '0;
            if (rd_strobe[i] && !cli_gnt[i]) begin
                starve_d[i] = (starve_q[i] == StarveMax) ? starve_q[i] : starve_q[i] + 1'b1;
            end
        end
    end

    // Host read data is live during the ack cycle and held afterwards.
    always_comb begin
        host_ack_d    = host_gnt;
        rd_ack_d      = cli_gnt;
        sel_d         = host_gnt ? host_addr[1:0] : sel_q;
        live_byte     = ram_rddata[{sel_q, 3'b000} +: 8];
        hold8_d       = host_ack_q ? live_byte : hold8_q;
        hold32_d      = host_ack_q ? ram_rddata : hold32_q;
        host_rddata   = host_ack_q ? live_byte : hold8_q;
        host_rddata32 = host_ack_q ? ram_rddata : hold32_q;
        host_ack      = host_ack_q;
        rd_ack        = rd_ack_q;
        rd_rddata     = ram_rddata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            host_ack_q <= 1'b0;
            rd_ack_q   <= '0;
            sel_q      <= '0;
            hold8_q    <= '0;
            hold32_q   <= '0;
            for (int i = 0; i < NUM_RD; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            host_ack_q <= host_ack_d;
            rd_ack_q   <= rd_ack_d;
            sel_q      <= sel_d;
            hold8_q    <= hold8_d;
            hold32_q   <= hold32_d;
            for (int i = 0; i < NUM_RD; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a round-robin/starvation instance and a fixed-priority
// instance share stimulus; expected ack sequences are queued and popped per cycle.
module tb_vram_arbiter;

    localparam int NR = 3;
    localparam int AW = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW+1:0]     host_addr;
    logic [1:0]        host_wrpattern;
    logic [31:0]       host_cache32;
    logic [7:0]        host_wrdata;
    logic              host_strobe;
    logic              host_write;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR-1:0]     rd_strobe;
    logic [31:0]       ram_rddata;

    logic              host_ack, fx_host_ack;
    logic [7:0]        host_rddata, fx_host_rddata;
    logic [31:0]       host_rddata32, fx_host_rddata32;
    logic [NR-1:0]     rd_ack, fx_rd_ack;
    logic [31:0]       rd_rddata, fx_rd_rddata;
    logic [AW-1:0]     ram_addr, fx_ram_addr;
    logic [31:0]       ram_wrdata, fx_ram_wrdata;
    logic [3:0]        ram_wrbytesel, fx_ram_wrbytesel;
    logic              ram_write, fx_ram_write;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int got, want;

    logic [3:0] be_tab [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0011, 4'b0110, 4'b1100, 4'b1001,
                                4'b0101, 4'b1010, 4'b0111, 4'b1110,
                                4'b1111, 4'b1111, 4'b1101, 4'b1011};

    always #5 clk = ~clk;

    vram_arbiter #(
        .NUM_RD(NR), .ADDR_W(AW), .ARB_MODE(1), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host_addr(host_addr), .host_wrpattern(host_wrpattern),
        .host_cache32(host_cache32), .host_wrdata(host_wrdata), .host_strobe(host_strobe),
        .host_write(host_write), .host_ack(host_ack), .host_rddata(host_rddata),
        .host_rddata32(host_rddata32), .rd_addr(rd_addr), .rd_strobe(rd_strobe),
        .rd_ack(rd_ack), .rd_rddata(rd_rddata), .ram_addr(ram_addr),
        .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel), .ram_write(ram_write),
        .ram_rddata(ram_rddata)
    );

    vram_arbiter #(
        .NUM_RD(NR), .ADDR_W(AW), .ARB_MODE(0), .STARVE_LIMIT(0)
    ) dut_fx (
        .clk(clk), .rst_n(rst_n), .host_addr(host_addr), .host_wrpattern(host_wrpattern),
        .host_cache32(host_cache32), .host_wrdata(host_wrdata), .host_strobe(host_strobe),
        .host_write(host_write), .host_ack(fx_host_ack), .host_rddata(fx_host_rddata),
        .host_rddata32(fx_host_rddata32), .rd_addr(rd_addr), .rd_strobe(rd_strobe),
        .rd_ack(fx_rd_ack), .rd_rddata(fx_rd_rddata), .ram_addr(fx_ram_addr),
        .ram_wrdata(fx_ram_wrdata), .ram_wrbytesel(fx_ram_wrbytesel),
        .ram_write(fx_ram_write), .ram_rddata(ram_rddata)
    );

    // 8 = host ack, 0..NR-1 = client ack, 9 = no ack, 10 = illegal combination
    function automatic int ack_id(input logic h, input logic [NR-1:0] r);
        int id;
        id = 10;
        if (r == '0) id = h ? 8 : 9;
        else if (!h && $onehot(r)) begin
            for (int i = 0; i < NR; i++) if (r[i]) id = i;
        end
        return id;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL reset_host_ack got=%b want=0", host_ack); end
        total++; if (rd_ack !== '0) begin bad++; $display("FAIL reset_rd_ack got=%b want=000", rd_ack); end
        total++; if (host_rddata !== 8'h00) begin bad++; $display("FAIL reset_rddata got=%h want=00", host_rddata); end
        total++; if (host_rddata32 !== 32'h0) begin bad++; $display("FAIL reset_rddata32 got=%h want=0", host_rddata32); end
        total++; if (ram_write !== 1'b0 || ram_addr !== '0) begin bad++; $display("FAIL reset_ram got=%b/%h want=0/0", ram_write, ram_addr); end
        total++; if (fx_rd_ack !== '0) begin bad++; $display("FAIL reset_fx_rd_ack got=%b want=000", fx_rd_ack); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_host_read();
        host_addr = 17'h00006; host_write = 1'b0; host_strobe = 1'b1;
        exp_q.push_back(8);
        #1;
        total++; if (ram_addr !== 15'd1 || ram_write !== 1'b0) begin bad++; $display("FAIL rd_ram_addr got=%h/%b want=0001/0", ram_addr, ram_write); end
        tick();
        host_strobe = 1'b0; ram_rddata = 32'hAABBCCDD;
        #1;
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL rd_ack_seq got=%0d want=%0d", got, want); end
        total++; if (host_rddata !== 8'hBB) begin bad++; $display("FAIL rd_byte got=%h want=bb", host_rddata); end
        total++; if (host_rddata32 !== 32'hAABBCCDD) begin bad++; $display("FAIL rd_word got=%h want=aabbccdd", host_rddata32); end
        tick();
        ram_rddata = 32'h11223344;
        #1;
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_once got=%b want=0", host_ack); end
        total++; if (host_rddata !== 8'hBB) begin bad++; $display("FAIL rd_hold_byte got=%h want=bb", host_rddata); end
        total++; if (host_rddata32 !== 32'hAABBCCDD) begin bad++; $display("FAIL rd_hold_word got=%h want=aabbccdd", host_rddata32); end
    endtask

    task automatic test_host_write();
        logic [31:0] exp32;
        host_addr = 17'h00000; host_wrpattern = 2'b11; host_cache32 = 32'h12345678;
        host_wrdata = 8'h00; host_write = 1'b1; host_strobe = 1'b1;
        exp_q.push_back(8);
        #1;
        total++; if (ram_wrbytesel !== 4'b1111) begin bad++; $display("FAIL wr_blit_be got=%b want=1111", ram_wrbytesel); end
        total++; if (ram_wrdata !== 32'h12345678) begin bad++; $display("FAIL wr_blit_data got=%h want=12345678", ram_wrdata); end
        total++; if (ram_write !== 1'b1) begin bad++; $display("FAIL wr_strobe got=%b want=1", ram_write); end
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL wr_ack_seq got=%0d want=%0d", got, want); end
        host_addr = 17'h00003; host_wrpattern = 2'b10; host_wrdata = 8'h5A;
        exp_q.push_back(8);
        #1;
        total++; if (ram_wrbytesel !== 4'b1110) begin bad++; $display("FAIL wr_skip_be got=%b want=1110", ram_wrbytesel); end
        total++; if (ram_wrdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL wr_skip_data got=%h want=5a5a5a5a", ram_wrdata); end
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL wr_b2b_ack got=%0d want=%0d", got, want); end
        // Full pattern/offset sweep, one write per cycle
        for (int p = 0; p < 4; p++) begin
            for (int o = 0; o < 4; o++) begin
                host_wrpattern = 2'(p); host_addr = 17'(20 + o); host_wrdata = 8'(p * 16 + o + 1);
                exp32 = (p == 3 && o == 0) ? host_cache32 : {4{host_wrdata}};
                exp_q.push_back(8);
                #1;
                total++; if (ram_wrbytesel !== be_tab[p*4+o]) begin bad++; $display("FAIL be_table p=%0d o=%0d got=%b want=%b", p, o, ram_wrbytesel, be_tab[p*4+o]); end
                total++; if (ram_wrdata !== exp32 || ram_addr !== 15'd5) begin bad++; $display("FAIL wr_sweep p=%0d o=%0d got=%h/%h want=%h/0005", p, o, ram_wrdata, ram_addr, exp32); end
                tick();
                got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
                total++; if (got !== want) begin bad++; $display("FAIL wr_sweep_ack got=%0d want=%0d", got, want); end
            end
        end
        host_strobe = 1'b0; host_write = 1'b0;
        #1;
        total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL wr_idle got=%b want=0", ram_write); end
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL wr_idle_ack got=%0d want=%0d", got, want); end
    endtask

    task automatic test_round_robin();
        rd_addr = {15'h0300, 15'h0200, 15'h0100};
        rd_strobe = 3'b111;
        for (int k = 0; k < 6; k++) exp_q.push_back(k % 3);
        #1;
        total++; if (ram_addr !== 15'h0100) begin bad++; $display("FAIL rr_first_addr got=%h want=0100", ram_addr); end
        for (int c = 0; c < 6; c++) begin
            tick();
            got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
            total++; if (got !== want) begin bad++; $display("FAIL rr_order step=%0d got=%0d want=%0d", c, got, want); end
            total++; if (fx_rd_ack !== 3'b001) begin bad++; $display("FAIL fixed_prio step=%0d got=%b want=001", c, fx_rd_ack); end
        end
        rd_strobe = 3'b000;
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL rr_idle got=%0d want=%0d", got, want); end
    endtask

    task automatic test_starve_read();
        host_addr = 17'h00008; host_write = 1'b0; host_strobe = 1'b1; rd_strobe = 3'b010;
        for (int k = 0; k < 6; k++) exp_q.push_back(k == 4 ? 1 : 8);
        for (int c = 0; c < 6; c++) begin
            tick();
            got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
            total++; if (got !== want) begin bad++; $display("FAIL starve_rd step=%0d got=%0d want=%0d", c, got, want); end
            total++; if (fx_host_ack !== 1'b1 || fx_rd_ack !== '0) begin bad++; $display("FAIL fx_no_starve step=%0d got=%b/%b want=1/000", c, fx_host_ack, fx_rd_ack); end
            if (c == 4) rd_strobe = 3'b000;
        end
        host_strobe = 1'b0;
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL starve_rd_idle got=%0d want=%0d", got, want); end
    endtask

    task automatic test_starve_write();
        host_addr = 17'h00004; host_wrpattern = 2'b00; host_write = 1'b1; host_strobe = 1'b1;
        rd_strobe = 3'b010;
        repeat (8) exp_q.push_back(8);
        for (int c = 0; c < 8; c++) begin
            tick();
            got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
            total++; if (got !== want) begin bad++; $display("FAIL starve_wr step=%0d got=%0d want=%0d", c, got, want); end
        end
        host_strobe = 1'b0; host_write = 1'b0;
        exp_q.push_back(1);
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL starve_wr_release got=%0d want=%0d", got, want); end
        rd_strobe = 3'b000;
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL starve_wr_idle got=%0d want=%0d", got, want); end
    endtask

    task automatic test_host_client0();
        host_addr = 17'h00000; host_write = 1'b0; host_strobe = 1'b1; rd_strobe = 3'b001;
        exp_q.push_back(8);
        exp_q.push_back(0);
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL hc0_first got=%0d want=%0d", got, want); end
        total++; if (fx_host_ack !== 1'b1 || fx_rd_ack !== '0) begin bad++; $display("FAIL fx_hc0_first got=%b/%b want=1/000", fx_host_ack, fx_rd_ack); end
        host_strobe = 1'b0;
        #1;
        total++; if (ram_addr !== 15'h0100) begin bad++; $display("FAIL hc0_addr got=%h want=0100", ram_addr); end
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL hc0_second got=%0d want=%0d", got, want); end
        total++; if (fx_rd_ack !== 3'b001) begin bad++; $display("FAIL fx_hc0_second got=%b want=001", fx_rd_ack); end
        rd_strobe = 3'b000;
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL hc0_idle got=%0d want=%0d", got, want); end
    endtask

    task automatic test_reset_mid();
        rd_strobe = 3'b001;
        exp_q.push_back(0);
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL rst_pre got=%0d want=%0d", got, want); end
        rd_strobe = 3'b000;
        host_addr = 17'h00001; host_write = 1'b0; host_strobe = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (host_rddata !== 8'h00 || host_rddata32 !== 32'h0) begin bad++; $display("FAIL rst_hold got=%h/%h want=00/0", host_rddata, host_rddata32); end
        tick();
        host_strobe = 1'b0;
        #1;
        total++; if (host_ack !== 1'b0 || rd_ack !== '0) begin bad++; $display("FAIL rst_ack_lost got=%b/%b want=0/000", host_ack, rd_ack); end
        total++; if (host_rddata !== 8'h00) begin bad++; $display("FAIL rst_rddata got=%h want=00", host_rddata); end
        #2 rst_n = 1'b1;
        rd_strobe = 3'b111;
        exp_q.push_back(0);
        #1;
        total++; if (ram_addr !== 15'h0100) begin bad++; $display("FAIL rst_rr_addr got=%h want=0100", ram_addr); end
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL rst_rr_ptr got=%0d want=%0d", got, want); end
        rd_strobe = 3'b000;
        tick();
        got = ack_id(host_ack, rd_ack); want = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
        total++; if (got !== want) begin bad++; $display("FAIL rst_idle got=%0d want=%0d", got, want); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        host_addr = '0; host_wrpattern = 2'b00; host_cache32 = '0; host_wrdata = '0;
        host_strobe = 1'b0; host_write = 1'b0;
        rd_addr = '0; rd_strobe = '0; ram_rddata = '0;
        test_reset();
        test_host_read();
        test_host_write();
        test_round_robin();
        test_starve_read();
        test_starve_write();
        test_host_client0();
        test_reset_mid();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Parametrised successor of the single-RAM VRAM access block: one 8-bit host port with write patterns/blit, plus NUM_RD 32-bit read-only client ports (layer and sprite fetch).
- Arbitrates one single-port RAM (1-cycle read latency) per clock.
- Selectable fixed-priority or round-robin client arbitration, starvation escalation above the host, explicit host ack, held host read data.
- Sits between the register/bus front end and the external main_ram; RAM is not instantiated inside.

Parameters:
NUM_RD, 3, number of read-only client channels (1..8)
ADDR_W, 15, RAM word address width (host byte address is ADDR_W+2)
ARB_MODE, 0, 0 = fixed priority (lower index wins), 1 = round-robin among clients
STARVE_LIMIT, 0, cycles a client may wait before preempting host; 0 disables escalation

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
host_addr  in  ADDR_W+2  host byte address
host_wrpattern  in  2  byte-enable pattern selector
host_cache32  in  32  blit write data
host_wrdata  in  8  byte write data
host_strobe  in  1  host request; held until host_ack
host_write  in  1  1 = write, 0 = read
host_ack  out  1  request serviced (cycle after grant)
host_rddata  out  8  selected byte
host_rddata32  out  32  full read word
rd_addr  in  NUM_RD*ADDR_W  packed client word addresses, channel i at [i*ADDR_W +: ADDR_W]
rd_strobe  in  NUM_RD  client requests; held until rd_ack
rd_ack  out  NUM_RD  one-hot; data valid on rd_rddata this cycle
rd_rddata  out  32  shared client read data (= ram_rddata)
ram_addr  out  ADDR_W  RAM word address
ram_wrdata  out  32  RAM write data
ram_wrbytesel  out  4  RAM byte enables
ram_write  out  1  RAM write strobe
ram_rddata  in  32  RAM read data, valid cycle after address

Behaviour:
- Grant is combinational in cycle N; matching ack registered, high in cycle N+1 only; at most one grant per cycle; no grant → ram_addr = 0, ram_write = 0.
- Priority order: (1) lowest-index client with starve counter == STARVE_LIMIT (only when STARVE_LIMIT > 0 and host_write = 0); (2) host; (3) clients per ARB_MODE.
- Host writes are never preempted.
- ARB_MODE 0: lowest strobing index wins.
- ARB_MODE 1: search starts at rr_ptr, wraps modulo NUM_RD; after a client grant, rr_ptr <= granted index + 1 (wraps NUM_RD-1 → 0); host or starvation grants do not move rr_ptr.
- Starve counter per client:
  - strobe high and not granted → increment, saturating at STARVE_LIMIT.
  - granted or strobe low → clear to 0.
  - Counter width is clog2(STARVE_LIMIT+1), minimum 1.
- Host grant: ram_addr = host_addr[ADDR_W+1:2]; ram_write = host_strobe & host_write.
- ram_wrdata = host_cache32 when pattern 11 and host_addr[1:0] = 00, else {4{host_wrdata}}.
- ram_wrbytesel, by pattern (rows) and host_addr[1:0] = 0/1/2/3 (columns):
  - 00: 0001 0010 0100 1000
  - 01: 0011 0110 1100 1001
  - 10: 0101 1010 0111 1110
  - 11: 1111 1111 1101 1011
- Host read:
  - Register host_addr[1:0] at grant.
  - During host_ack: host_rddata = selected byte of ram_rddata, host_rddata32 = ram_rddata, and both are captured into hold registers.
  - Outside host_ack: hold registers drive the outputs.
  - Host writes also raise host_ack; read data is don't-care during a write ack.
- Host strobe dropped before grant → request withdrawn, no ack.
- Client strobe dropped while starving → counter clears.
- Back-to-back grants allowed every cycle: a new strobe in the ack cycle is re-arbitrated normally.
- Reset, asynchronous, any time including mid-transfer: all acks 0, rr_ptr 0, starve counters 0, host hold registers 0, registered byte select 0; pending acks are lost and requesters must re-strobe.

Decomposition:
- Shared package vera_vram_pkg: ARB_FIXED/ARB_RR constants, PAT_BYTE/PAT_PAIR/PAT_SKIP/PAT_BLIT pattern codes, RAM_DATA_W = 32.
- One sub-module, vram_rr_pick: parametrised round-robin/fixed priority picker (request vector, start pointer, mode → one-hot grant plus index).
- Byte-enable table, starve counters and read hold stay in the top.

Test Plan:
- Reset, then host read at byte addr 0x00006 with ram_rddata = 0xAABBCCDD the following cycle → host_ack 1 cycle later, host_rddata 0xBB, held at 0xBB after ack; host_rddata32 0xAABBCCDD.
- Host write, pattern 11, addr 0x00000, cache32 0x12345678 → ram_wrbytesel 1111, ram_wrdata 0x12345678. Pattern 10, addr 3, wrdata 0x5A → bytesel 1110, wrdata 0x5A5A5A5A.
- ARB_MODE 1, NUM_RD 3, all rd_strobe held for 6 cycles, no host → rd_ack order 0,1,2,0,1,2.
- STARVE_LIMIT 4, host reads every cycle, client 1 strobing → client 1 granted on the 5th cycle of waiting and host_ack skips that cycle. Same setup with host writes → client 1 never granted while writes continue.
- Host and client 0 strobe together, ARB_MODE 0 → host granted first, client 0 next cycle; rd_ack[0] two cycles after strobe.
- rst_n asserted in the cycle between grant and ack → no ack emitted, host_rddata 0x00, rr_ptr back to 0 (next RR grant goes to client 0).
